// File: rtl/irq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : irq_pkg                                                        |
// | Purpose : Shared constants and types for the interrupt controller:      |
// |           Wishbone register word offsets, vector width, vector type and  |
// |           the bus-handshake state encoding.                              |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package irq_pkg;

  // Vector width presented to the CPU (0 = no interrupt, 1..7 = source).
  localparam int IRQ_VEC_W = 3;

  // Register word offsets (adr_i = cpu_address[3:2]).
  localparam logic [1:0] IRQ_STATUS  = 2'd0;
  localparam logic [1:0] IRQ_PENDING = 2'd1;
  localparam logic [1:0] IRQ_MASK    = 2'd2;
  localparam logic [1:0] IRQ_VECTOR  = 2'd3;

  typedef logic [IRQ_VEC_W-1:0] irq_vec_t;

  // Bus handshake: a strobe in IDLE moves to ACK for exactly one cycle.
  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : irq_prio_enc                                                   |
// | Purpose : Combinational priority encoder. The highest set request bit i  |
// |           produces vector NSRC-i; no request produces 0.                 |
// | Ports   : req_i [NSRC-1:0]  masked pending requests                      |
// |           vec_o [2:0]       encoded vector                               |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NSRC = 7
) (
  input  logic [NSRC-1:0] req_i,
  output irq_vec_t        vec_o
);

  // Ascending scan: later (higher) bits overwrite earlier ones, so the
  // highest set bit wins.
  always_comb begin
    vec_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (req_i[i]) begin
        vec_o = irq_vec_t'(NSRC - i);
      end
    end
  end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : irq_controller                                                 |
// | Purpose : Registered interrupt controller. Latches source requests into |
// |           PENDING, applies a software MASK, priority-encodes to a 3-bit |
// |           vector for the CPU and exposes a Wishbone slave for           |
// |           STATUS/PENDING/MASK/VECTOR access.                             |
// | Config  : IRQ_CTRL_EDGE_EN defined  -> rising-edge capture into PENDING, |
// |                                        cleared by write-1-to-clear.      |
// |           IRQ_CTRL_EDGE_EN undefined -> level mode, PENDING = live src_i,|
// |                                        W1C writes acked and ignored.     |
// | Ports   : clk_i, rst_i (async, active high)                              |
// |           src_i[NSRC-1:0] request lines, int_en_i global enable          |
// |           irq_o[2:0] vector to CPU                                       |
// |           adr_i, dat_i, dat_o, we_i, sel_i, stb_i, cyc_i, ack_o (WB)     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module irq_controller
  import irq_pkg::*;
#(
  parameter int NSRC = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NSRC-1:0]      src_i,
  input  logic                 int_en_i,
  output logic [IRQ_VEC_W-1:0] irq_o,
  input  logic [1:0]           adr_i,
  input  logic [31:0]          dat_i,
  output logic [31:0]          dat_o,
  input  logic                 we_i,
  input  logic [3:0]           sel_i,
  input  logic                 stb_i,
  input  logic                 cyc_i,
  output logic                 ack_o
);

  // ---------------------------------------------------------------------------
  // Bus handshake FSM
  // ---------------------------------------------------------------------------
  bus_state_e state_q, state_d;
  logic       rd_load;     // capture read data on the edge that raises ack
  logic       wr_commit;   // register write completes on the edge ending ack

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_load   = 1'b0;
    wr_commit = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (stb_i && cyc_i) begin
          state_d = BUS_ACK;
          rd_load = 1'b1;
        end
      end
      BUS_ACK: begin
        state_d   = BUS_IDLE;
        // A master that drops cyc_i during the ack cycle abandons the
        // transfer; only a still-valid cycle commits the write.
        wr_commit = stb_i && cyc_i && we_i && sel_i[0];
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  assign ack_o = (state_q == BUS_ACK);

  logic w_wr_pend;
  logic w_wr_mask;
  assign w_wr_pend = wr_commit && (adr_i == IRQ_PENDING);
  assign w_wr_mask = wr_commit && (adr_i == IRQ_MASK);

  // ---------------------------------------------------------------------------
  // MASK register (1 = source enabled)
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (w_wr_mask) begin
      mask_d = dat_i[NSRC-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  // ---------------------------------------------------------------------------
  // PENDING
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] pending;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NSRC-1:0] src_prev_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] w_rise;

  assign w_rise = src_i & ~src_prev_q;

  // Clear is applied before set so a new edge in the same cycle as its W1C
  // keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (w_wr_pend) begin
      pending_d = pending_d & ~dat_i[NSRC-1:0];
    end
    pending_d = pending_d | w_rise;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      src_prev_q <= src_i;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  // Level mode: PENDING is the live request vector; W1C has nothing to clear.
  logic w_unused_w1c;
  assign w_unused_w1c = w_wr_pend;
  assign pending      = src_i;
`endif

  // ---------------------------------------------------------------------------
  // Priority encode and registered vector output
  // ---------------------------------------------------------------------------
  irq_vec_t w_vec;
  irq_vec_t irq_q, irq_d;

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .req_i (pending & mask_q),
    .vec_o (w_vec)
  );

  // Global disable gates only the output; PENDING keeps accumulating.
  assign irq_d = int_en_i ? w_vec : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

  // ---------------------------------------------------------------------------
  // Read data, registered together with ack
  // ---------------------------------------------------------------------------
  logic [31:0] w_rd_data;
  logic [31:0] dat_q, dat_d;

  always_comb begin
    w_rd_data = '0;
    case (adr_i)
      IRQ_STATUS:  w_rd_data[NSRC-1:0]      = src_i;
      IRQ_PENDING: w_rd_data[NSRC-1:0]      = pending;
      IRQ_MASK:    w_rd_data[NSRC-1:0]      = mask_q;
      IRQ_VECTOR:  w_rd_data[IRQ_VEC_W-1:0] = irq_q;
      default:     w_rd_data                = '0;
    endcase
  end

  always_comb begin
    dat_d = dat_q;
    if (rd_load) begin
      dat_d = w_rd_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_q <= '0;
    end else begin
      dat_q <= dat_d;
    end
  end

  assign dat_o = dat_q;

  // Upper data bits and upper byte selects carry nothing for these registers.
  logic w_unused_bus;
  assign w_unused_bus = ^{dat_i[31:NSRC], sel_i[3:1]};

endmodule : irq_controller
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_irq_controller                                              |
// | Purpose : Self-checking bench for irq_controller: directed scenarios    |
// |           followed by randomized traffic against a behavioural model.   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_irq_controller;

  localparam int NSRC = 7;
`ifdef IRQ_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  src = '0;
  logic        int_en = 1'b1;
  logic [2:0]  irq_o;
  logic [1:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] dat_o;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        ack_o;

  int vectors = 0;
  int misses  = 0;

  irq_controller #(.NSRC(NSRC)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .src_i    (src),
    .int_en_i (int_en),
    .irq_o    (irq_o),
    .adr_i    (adr),
    .dat_i    (wdat),
    .dat_o    (dat_o),
    .we_i     (we),
    .sel_i    (sel),
    .stb_i    (stb),
    .cyc_i    (cyc),
    .ack_o    (ack_o)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [6:0] m_pend = '0;
  logic [6:0] m_mask = 7'h7f;
  logic [6:0] m_prev = '0;
  logic [2:0] m_irq  = '0;

  // Highest requesting source index i maps to vector NSRC-i.
  function automatic logic [2:0] prio(input logic [6:0] v);
    int best;
    best = -1;
    for (int i = 0; i < NSRC; i++) if (v[i]) best = i;
    return (best < 0) ? 3'd0 : 3'(NSRC - best);
  endfunction

  function automatic logic [6:0] eff_pend();
    return EDGE ? m_pend : src;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model using the inputs as they stand, then check irq_o.
  task automatic cycle(input bit commit, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [6:0] pend_n, mask_n;
    logic [2:0] irq_n;
    irq_n  = int_en ? prio(eff_pend() & m_mask) : 3'd0;
    pend_n = m_pend;
    mask_n = m_mask;
    if (commit && s[0] && a == 2'd1) pend_n = pend_n & ~d[6:0];
    if (commit && s[0] && a == 2'd2) mask_n = d[6:0];
    pend_n = pend_n | (src & ~m_prev);
    @(posedge clk);
    #1;
    m_pend = pend_n;
    m_mask = mask_n;
    m_irq  = irq_n;
    m_prev = src;
    chk("irq_model", {29'd0, irq_o}, {29'd0, m_irq});
  endtask

  task automatic tick();
    cycle(1'b0, 2'd0, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s, input logic [6:0] src_commit);
    adr = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    tick();
    chk("wr_ack_rise", {31'd0, ack_o}, 32'd1);
    src = src_commit;
    cycle(1'b1, a, d, s);
    chk("wr_ack_fall", {31'd0, ack_o}, 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] got);
    logic [31:0] exp;
    case (a)
      2'd0:    exp = {25'd0, src};
      2'd1:    exp = {25'd0, eff_pend()};
      2'd2:    exp = {25'd0, m_mask};
      default: exp = {29'd0, m_irq};
    endcase
    adr = a; we = 1'b0; sel = 4'hf; stb = 1'b1; cyc = 1'b1;
    tick();
    chk("rd_ack_rise", {31'd0, ack_o}, 32'd1);
    chk("rd_data", dat_o, exp);
    got = dat_o;
    stb = 1'b0; cyc = 1'b0;
    tick();
    chk("rd_ack_fall", {31'd0, ack_o}, 32'd0);
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = 7'h7f; m_prev = '0; m_irq = '0;
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  ra;

    // Reset state
    #12;
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_irq", {29'd0, irq_o}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst = 1'b0;
    model_reset();
    tick();
    rd(2'd2, r); chk("rst_mask", r, 32'h7f);
    rd(2'd1, r); chk("rst_pend", r, 32'h0);

    // cyc_i dropped during ack: no write side effect
    adr = 2'd2; wdat = 32'h0; sel = 4'h1; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    tick();
    chk("abort_ack_rise", {31'd0, ack_o}, 32'd1);
    cyc = 1'b0;
    tick();
    chk("abort_ack_fall", {31'd0, ack_o}, 32'd0);
    stb = 1'b0; we = 1'b0;
    rd(2'd2, r); chk("abort_mask", r, 32'h7f);

    // Write with sel_i[0] clear is acked but ignored
    wr(2'd2, 32'h0, 4'he, src);
    rd(2'd2, r); chk("sel0_mask", r, 32'h7f);

`ifdef IRQ_CTRL_EDGE_EN
    src = 7'h41; tick(); src = 7'h00; tick();
    chk("edge_pulse_6_0", {29'd0, irq_o}, 32'd1);
    wr(2'd1, 32'h40, 4'h1, 7'h00); tick();
    chk("edge_w1c_40", {29'd0, irq_o}, 32'd7);
    wr(2'd1, 32'h01, 4'h1, 7'h00); tick();
    chk("edge_w1c_01", {29'd0, irq_o}, 32'd0);

    src = 7'h40; tick(); src = 7'h00; tick();
    wr(2'd2, 32'h3f, 4'h1, 7'h00); tick();
    chk("mask_3f", {29'd0, irq_o}, 32'd0);
    wr(2'd2, 32'h7f, 4'h1, 7'h00); tick();
    chk("mask_7f", {29'd0, irq_o}, 32'd1);
    wr(2'd1, 32'h40, 4'h1, 7'h00); tick();

    int_en = 1'b0;
    src = 7'h08; tick(); src = 7'h00; tick(); tick();
    chk("inten_off", {29'd0, irq_o}, 32'd0);
    rd(2'd1, r); chk("inten_pend", r, 32'h08);
    int_en = 1'b1; tick();
    chk("inten_on", {29'd0, irq_o}, 32'd4);
    wr(2'd1, 32'h08, 4'h1, 7'h00); tick();

    src = 7'h04; tick(); src = 7'h00; tick(); tick();
    chk("src2_set", {29'd0, irq_o}, 32'd5);
    wr(2'd1, 32'h04, 4'h1, 7'h04); src = 7'h00; tick();
    chk("set_wins_irq", {29'd0, irq_o}, 32'd5);
    rd(2'd1, r); chk("set_wins_pend", r, 32'h04);
    wr(2'd1, 32'h04, 4'h1, 7'h00); tick();
    chk("src2_clr", {29'd0, irq_o}, 32'd0);
`else
    src = 7'h02; tick(); tick();
    chk("lvl_hold1", {29'd0, irq_o}, 32'd6);
    wr(2'd1, 32'h02, 4'h1, 7'h02); tick();
    chk("lvl_w1c_ign", {29'd0, irq_o}, 32'd6);
    rd(2'd1, r); chk("lvl_pend", r, 32'h02);
    src = 7'h00; tick();
    chk("lvl_drop", {29'd0, irq_o}, 32'd0);

    src = 7'h40;
    wr(2'd2, 32'h3f, 4'h1, 7'h40); tick();
    chk("mask_3f", {29'd0, irq_o}, 32'd0);
    wr(2'd2, 32'h7f, 4'h1, 7'h40); tick();
    chk("mask_7f", {29'd0, irq_o}, 32'd1);
    src = 7'h00; tick();

    int_en = 1'b0; src = 7'h08; tick(); tick();
    chk("inten_off", {29'd0, irq_o}, 32'd0);
    int_en = 1'b1; tick();
    chk("inten_on", {29'd0, irq_o}, 32'd4);
    src = 7'h00; tick();
`endif

    // Reset during an acked write: ack drops at once, write discarded
    adr = 2'd2; wdat = 32'h0; sel = 4'h1; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    tick();
    chk("rstmid_ack_rise", {31'd0, ack_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_ack", {31'd0, ack_o}, 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; src = 7'h00;
    #3 rst = 1'b0;
    model_reset();
    tick();
    rd(2'd2, r); chk("rstmid_mask", r, 32'h7f);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if (EDGE) src = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
      else      src = 7'($urandom);
      int_en = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 7))
        0: wr(2'd1, $urandom, 4'($urandom), src);
        1: wr(2'd2, $urandom, 4'($urandom), src);
        2: begin ra = 2'($urandom); rd(ra, r); end
        default: tick();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule : tb_irq_controller
`default_nettype wire
